// File: rtl/alu_bit_test.sv
// Nibble-serial SM83 BIT b,r flag unit: latch, low nibble, high nibble, flags.
// Optional ALU_BIT_TEST_B2B_EN: accept a new start in the FLAG cycle.
module alu_bit_test (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] op_a,
    input  logic [2:0] bit_sel,
    input  logic       c_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] nib_out,
    output logic [7:0] result,
    output logic       z_out,
    output logic       n_out,
    output logic       h_out,
    output logic       c_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FLAG = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       accept;
    logic [7:0] opa_q;
    logic [2:0] sel_q;
    logic       c_q;
    logic       zacc;
    logic       bit_val;
    logic       lo_term;
    logic       hi_term;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = LO;
                end
            end
            LO:   state_nx = HI;
            HI:   state_nx = FLAG;
            FLAG: begin
`ifdef ALU_BIT_TEST_B2B_EN
                if (start) begin
                    accept   = 1'b1;
                    state_nx = LO;
                end else begin
                    state_nx = IDLE;
                end
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // Only the nibble that holds the selected bit may clear Z.
    assign bit_val = opa_q[sel_q];
    assign lo_term = sel_q[2] ? 1'b1 : ~bit_val;
    assign hi_term = sel_q[2] ? ~bit_val : 1'b1;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state  <= IDLE;
            opa_q  <= 8'h00;
            sel_q  <= 3'd0;
            c_q    <= 1'b0;
            zacc   <= 1'b0;
            result <= 8'h00;
            z_out  <= 1'b0;
            n_out  <= 1'b0;
            h_out  <= 1'b0;
            c_out  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                opa_q <= op_a;
                sel_q <= bit_sel;
                c_q   <= c_in;
            end
            if (state == LO) begin
                zacc <= lo_term;
            end
            // Registered on the HI->FLAG edge so flags are visible during FLAG.
            if (state == HI) begin
                z_out  <= zacc & hi_term;
                n_out  <= 1'b0;
                h_out  <= 1'b1;
                c_out  <= c_q;
                result <= opa_q;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FLAG);

    always_comb begin
        nib_out = 4'h0;
        unique case (state)
            LO:      nib_out = opa_q[3:0];
            HI:      nib_out = opa_q[7:4];
            default: nib_out = 4'h0;
        endcase
    end

endmodule

// File: tb/tb_alu_bit_test.sv
// Self-checking bench for alu_bit_test with a flag-level reference model.
// Honours ALU_BIT_TEST_B2B_EN for the back-to-back issue check.
module tb_alu_bit_test;

    logic       clk = 1'b0;
    logic       nreset;
    logic       start;
    logic [7:0] op_a;
    logic [2:0] bit_sel;
    logic       c_in;
    logic       busy;
    logic       done;
    logic [3:0] nib_out;
    logic [7:0] result;
    logic       z_out;
    logic       n_out;
    logic       h_out;
    logic       c_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_res;
    logic       m_z;
    logic       m_n;
    logic       m_h;
    logic       m_c;

    always #5 clk = ~clk;

    alu_bit_test dut (
        .clk     (clk),
        .nreset  (nreset),
        .start   (start),
        .op_a    (op_a),
        .bit_sel (bit_sel),
        .c_in    (c_in),
        .busy    (busy),
        .done    (done),
        .nib_out (nib_out),
        .result  (result),
        .z_out   (z_out),
        .n_out   (n_out),
        .h_out   (h_out),
        .c_out   (c_out)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".z"}, {7'd0, z_out}, {7'd0, m_z});
        chk({tag, ".n"}, {7'd0, n_out}, {7'd0, m_n});
        chk({tag, ".h"}, {7'd0, h_out}, {7'd0, m_h});
        chk({tag, ".c"}, {7'd0, c_out}, {7'd0, m_c});
        chk({tag, ".res"}, result, m_res);
    endtask

    task automatic model_bit(input logic [7:0] op, input logic [2:0] b,
                             input logic c);
        int idx;
        idx   = int'(b);
        m_z   = ((op >> idx) & 8'd1) == 8'd0;
        m_n   = 1'b0;
        m_h   = 1'b1;
        m_c   = c;
        m_res = op;
    endtask

    // One full op from IDLE; returns at the FLAG-cycle negedge with start low.
    task automatic run_op(input logic [7:0] op, input logic [2:0] b,
                          input logic c, input logic hold);
        @(negedge clk);
        chk("idle.busy", {7'd0, busy}, 8'd0);
        chk("idle.done", {7'd0, done}, 8'd0);
        op_a = op; bit_sel = b; c_in = c; start = 1'b1;
        @(negedge clk);
        chk("lo.busy", {7'd0, busy}, 8'd1);
        chk("lo.done", {7'd0, done}, 8'd0);
        chk("lo.nib", {4'd0, nib_out}, {4'd0, op[3:0]});
        chk_flags("lo.hold");
        start = hold; op_a = ~op; bit_sel = b ^ 3'd4; c_in = ~c;
        @(negedge clk);
        chk("hi.done", {7'd0, done}, 8'd0);
        chk("hi.nib", {4'd0, nib_out}, {4'd0, op[7:4]});
        chk_flags("hi.hold");
        start = 1'b0;
        @(negedge clk);
        model_bit(op, b, c);
        chk("flag.done", {7'd0, done}, 8'd1);
        chk("flag.busy", {7'd0, busy}, 8'd1);
        chk("flag.nib", {4'd0, nib_out}, 8'd0);
        chk_flags("flag");
    endtask

    initial begin
        nreset = 1'b0; start = 1'b0; op_a = 8'h00; bit_sel = 3'd0; c_in = 1'b0;
        m_res = 8'h00; m_z = 1'b0; m_n = 1'b0; m_h = 1'b0; m_c = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", {7'd0, busy}, 8'd0);
        chk("rst.done", {7'd0, done}, 8'd0);
        chk("rst.nib", {4'd0, nib_out}, 8'd0);
        chk_flags("rst");
        nreset = 1'b1;

        for (int b = 0; b < 8; b++) run_op(8'h00, 3'(b), 1'b0, 1'b0);
        run_op(8'hFF, 3'd0, 1'b0, 1'b0);
        run_op(8'hFF, 3'd3, 1'b0, 1'b0);
        run_op(8'hFF, 3'd4, 1'b0, 1'b0);
        run_op(8'hFF, 3'd7, 1'b0, 1'b0);
        run_op(8'h5A, 3'd0, 1'b0, 1'b0);
        run_op(8'h5A, 3'd1, 1'b0, 1'b0);
        run_op(8'h5A, 3'd6, 1'b0, 1'b0);
        run_op(8'h01, 3'd0, 1'b1, 1'b0);
        run_op(8'h3C, 3'd2, 1'b1, 1'b1);

        // Issue from the FLAG cycle of the previous op.
        run_op(8'h5A, 3'd7, 1'b0, 1'b0);
        op_a = 8'h80; bit_sel = 3'd7; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef ALU_BIT_TEST_B2B_EN
        chk("b2b.busy", {7'd0, busy}, 8'd1);
        chk("b2b.done", {7'd0, done}, 8'd0);
        chk("b2b.lonib", {4'd0, nib_out}, 8'h00);
        chk_flags("b2b.lo");
        @(negedge clk);
        chk("b2b.hinib", {4'd0, nib_out}, 8'h08);
        @(negedge clk);
        model_bit(8'h80, 3'd7, 1'b1);
        chk("b2b.fdone", {7'd0, done}, 8'd1);
        chk_flags("b2b.flag");
`else
        chk("drop.busy", {7'd0, busy}, 8'd0);
        chk("drop.done", {7'd0, done}, 8'd0);
        @(negedge clk);
        chk("drop.busy2", {7'd0, busy}, 8'd0);
        chk_flags("drop");
`endif

        // Abort in HI.
        @(negedge clk);
        op_a = 8'h5A; bit_sel = 3'd1; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abt.hi", {7'd0, busy}, 8'd1);
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        m_res = 8'h00; m_z = 1'b0; m_n = 1'b0; m_h = 1'b0; m_c = 1'b0;
        chk("abt.busy", {7'd0, busy}, 8'd0);
        chk("abt.done", {7'd0, done}, 8'd0);
        chk("abt.nib", {4'd0, nib_out}, 8'd0);
        chk_flags("abt");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abt.nodone", {7'd0, done}, 8'd0);
        end
        run_op(8'h5A, 3'd1, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op(8'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
